// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage floating-point multiplier with valid/ready,
// round-to-nearest-even, special values and exception flags.
module fp_mul_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] o,
   output logic [3:0]           flags
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int E2   = EXP_W + 2;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int BIAS = 2 ** (EXP_W - 1) - 1;
   localparam int EMAX = 2 ** EXP_W - 1;

   localparam logic [W-1:0] QNAN =
      {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [1:0] {
      K_NORM, K_ZERO, K_INF, K_NAN
   } kind_e;

   logic en;

   // ---------------- S1: unpack / classify ----------------
   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign {sa, ea, fa} = a;
   assign {sb, eb, fb} = b;
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (&ea) & ~(|fa);
   assign b_inf  = (&eb) & ~(|fb);
   assign a_nan  = (&ea) & (|fa);
   assign b_nan  = (&eb) & (|fb);

   kind_e                s1_kind_d, s1_kind_q;
   logic                 s1_inv_d, s1_inv_q;
   logic signed [E2-1:0] s1_exp_d, s1_exp_q;
   logic                 s1_v_q, s1_sign_q;
   logic [MAN_W:0]       s1_ma_q, s1_mb_q;

   // subnormals count as zero here, so Inf x subnormal is invalid
   always_comb begin
      s1_kind_d = K_NORM;
      s1_inv_d  = 1'b0;
      if (a_nan | b_nan) begin
         s1_kind_d = K_NAN;
      end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
         s1_kind_d = K_NAN;
         s1_inv_d  = 1'b1;
      end else if (a_inf | b_inf) begin
         s1_kind_d = K_INF;
      end else if (a_zero | b_zero) begin
         s1_kind_d = K_ZERO;
      end
   end

   assign s1_exp_d = $signed({2'b00, ea}) + $signed({2'b00, eb})
                   - $signed(E2'(BIAS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_kind_q <= K_NORM;
         s1_inv_q  <= 1'b0;
         s1_exp_q  <= '0;
         s1_ma_q   <= '0;
         s1_mb_q   <= '0;
      end else if (en) begin
         s1_v_q    <= in_valid;
         s1_sign_q <= sa ^ sb;
         s1_kind_q <= s1_kind_d;
         s1_inv_q  <= s1_inv_d;
         s1_exp_q  <= s1_exp_d;
         s1_ma_q   <= {1'b1, fa};
         s1_mb_q   <= {1'b1, fb};
      end
   end

   // ---------------- S2: mantissa product ----------------
   logic                 s2_v_q, s2_sign_q, s2_inv_q;
   kind_e                s2_kind_q;
   logic signed [E2-1:0] s2_exp_q;
   logic [PW-1:0]        s2_prod_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q    <= 1'b0;
         s2_sign_q <= 1'b0;
         s2_kind_q <= K_NORM;
         s2_inv_q  <= 1'b0;
         s2_exp_q  <= '0;
         s2_prod_q <= '0;
      end else if (en) begin
         s2_v_q    <= s1_v_q;
         s2_sign_q <= s1_sign_q;
         s2_kind_q <= s1_kind_q;
         s2_inv_q  <= s1_inv_q;
         s2_exp_q  <= s1_exp_q;
         s2_prod_q <= PW'(s1_ma_q) * PW'(s1_mb_q);
      end
   end

   // ---------------- S3: normalise / round / pack ----------------
   logic [PW-1:0]        pn;
   logic [MAN_W:0]       mant;
   logic [MAN_W+1:0]     mr;
   logic                 guard, sticky, rup, carry;
   logic [E2-1:0]        inc;
   logic signed [E2-1:0] ef;
   logic                 ovf, unf;
   logic [W-1:0]         o_d, o_q;
   logic [3:0]           flags_d, flags_q;
   logic                 out_valid_q;

   // product in [1,4): align so the leading one sits at the MSB
   assign pn     = s2_prod_q[PW-1] ? s2_prod_q : (s2_prod_q << 1);
   assign mant   = pn[PW-1 -: MAN_W+1];
   assign guard  = pn[MAN_W];
   assign sticky = |pn[MAN_W-1:0];
   assign rup    = guard & (sticky | mant[0]);
   assign mr     = {1'b0, mant} + (MAN_W+2)'(rup);
   assign carry  = mr[MAN_W+1];
   assign inc    = E2'(s2_prod_q[PW-1]) + E2'(carry);
   assign ef     = s2_exp_q + $signed(inc);
   assign ovf    = (ef >= $signed(E2'(EMAX)));
   assign unf    = (ef <= $signed(E2'(0)));

   // on a rounding carry mr is 10..0, so its low bits are already 0
   always_comb begin
      o_d     = '0;
      flags_d = 4'b0000;
      unique case (s2_kind_q)
         K_NAN: begin
            o_d     = QNAN;
            flags_d = {s2_inv_q, 3'b000};
         end
         K_INF: o_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         K_ZERO: o_d = {s2_sign_q, {(W-1){1'b0}}};
         default: begin
            if (ovf) begin
               o_d     = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags_d = 4'b0101;
            end else if (unf) begin
               o_d     = {s2_sign_q, {(W-1){1'b0}}};
               flags_d = 4'b0011;
            end else begin
               o_d     = {s2_sign_q, ef[EXP_W-1:0], mr[MAN_W-1:0]};
               flags_d = {3'b000, guard | sticky};
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         o_q         <= '0;
         flags_q     <= 4'b0000;
      end else if (en) begin
         out_valid_q <= s2_v_q;
         o_q         <= s2_v_q ? o_d : '0;
         flags_q     <= s2_v_q ? flags_d : 4'b0000;
      end
   end

   assign in_ready  = !out_valid_q || out_ready;
   assign en        = in_ready;
   assign out_valid = out_valid_q;
   assign o         = o_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: scoreboard bench for the pipelined binary16 multiplier.
// Expected {o, flags} are queued at issue and popped on each result.
module tb_fp_mul_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] o;
   logic [3:0]  flags;

   int checks = 0;
   int passes = 0;

   logic [19:0] sb_q[$];

   // {a, b, o, flags}
   logic [51:0] tv [0:18] = '{
      52'h3E00_4000_4200_0,
      52'h4000_4000_4400_0,
      52'hC000_3E00_C200_0,
      52'h4200_4200_4880_0,
      52'h7BFF_4000_7C00_5,
      52'hFBFF_4000_FC00_5,
      52'h7BFF_7BFF_7C00_5,
      52'h7C00_0000_7E00_8,
      52'h7E00_3C00_7E00_0,
      52'h0001_3C00_0000_0,
      52'hFC00_4000_FC00_0,
      52'h8000_4000_8000_0,
      52'h0001_7C00_7E00_8,
      52'h7C00_FE00_7E00_0,
      52'h3C03_3E00_3E04_1,
      52'h3C01_3C01_3C02_1,
      52'h0400_3800_0000_3,
      52'h3DA8_3DA8_4000_1,
      52'h8400_0400_8000_3
   };

   fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid);
      else passes++;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready);
      else passes++;
      checks++;
      if (o !== 16'h0000) $display("FAIL rst_o got %h want 0000", o);
      else passes++;
      checks++;
      if (flags !== 4'b0000) $display("FAIL rst_flags got %b want 0000", flags);
      else passes++;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      @(negedge clk);
      {a, b} = tv[0][51:20];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL lat_c1 out_valid got %b want 0", out_valid);
      else passes++;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL lat_c2 out_valid got %b want 0", out_valid);
      else passes++;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {o, flags} !== tv[0][19:0])
         $display("FAIL lat_c3 v/o/flags got %b/%h/%b want 1/%h/%b",
                  out_valid, o, flags, tv[0][19:4], tv[0][3:0]);
      else passes++;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL lat_c4 out_valid got %b want 0", out_valid);
      else passes++;
   endtask

   task automatic test_overflow();
      int i = 4;
      logic [19:0] e;
      out_ready = 1'b1;
      for (int c = 0; c < 30 && (i < 7 || sb_q.size() != 0); c++) begin
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (sb_q.size() == 0) $display("FAIL ovf spurious o=%h want none", o);
            else begin
               e = sb_q.pop_front();
               if ({o, flags} !== e)
                  $display("FAIL ovf o/flags got %h/%b want %h/%b", o, flags, e[19:4], e[3:0]);
               else passes++;
            end
         end
         if (i < 7) begin
            {a, b} = tv[i][51:20];
            sb_q.push_back(tv[i][19:0]);
            in_valid = 1'b1;
            i++;
         end else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         $display("FAIL ovf timeout got %0d pending want 0", sb_q.size());
         sb_q.delete();
      end else passes++;
   endtask

   task automatic test_specials();
      int i = 7;
      logic [19:0] e;
      out_ready = 1'b1;
      for (int c = 0; c < 30 && (i < 14 || sb_q.size() != 0); c++) begin
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (sb_q.size() == 0) $display("FAIL spec spurious o=%h want none", o);
            else begin
               e = sb_q.pop_front();
               if ({o, flags} !== e)
                  $display("FAIL spec o/flags got %h/%b want %h/%b", o, flags, e[19:4], e[3:0]);
               else passes++;
            end
         end
         if (i < 14) begin
            {a, b} = tv[i][51:20];
            sb_q.push_back(tv[i][19:0]);
            in_valid = 1'b1;
            i++;
         end else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         $display("FAIL spec timeout got %0d pending want 0", sb_q.size());
         sb_q.delete();
      end else passes++;
   endtask

   task automatic test_rounding();
      int i = 14;
      logic [19:0] e;
      out_ready = 1'b1;
      for (int c = 0; c < 30 && (i < 19 || sb_q.size() != 0); c++) begin
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (sb_q.size() == 0) $display("FAIL rnd spurious o=%h want none", o);
            else begin
               e = sb_q.pop_front();
               if ({o, flags} !== e)
                  $display("FAIL rnd o/flags got %h/%b want %h/%b", o, flags, e[19:4], e[3:0]);
               else passes++;
            end
         end
         if (i < 19) begin
            {a, b} = tv[i][51:20];
            sb_q.push_back(tv[i][19:0]);
            in_valid = 1'b1;
            i++;
         end else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         $display("FAIL rnd timeout got %0d pending want 0", sb_q.size());
         sb_q.delete();
      end else passes++;
   endtask

   task automatic test_back_to_back();
      int idx [6];
      int i = 0;
      int got = 0;
      logic stalled = 1'b0;
      logic saw_block = 1'b0;
      logic [19:0] held = '0;
      logic [19:0] e;
      idx = '{0, 1, 2, 3, 17, 15};
      for (int c = 0; c < 40 && got < 6; c++) begin
         @(negedge clk);
         out_ready = (c >= 5);
         #1;
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || {o, flags} !== held)
               $display("FAIL bp_hold v/o/flags got %b/%h/%b want 1/%h/%b",
                        out_valid, o, flags, held[19:4], held[3:0]);
            else passes++;
         end
         stalled = out_valid && !out_ready;
         held = {o, flags};
         if (!in_ready) saw_block = 1'b1;
         if (out_valid && out_ready) begin
            checks++;
            got++;
            if (sb_q.size() == 0) $display("FAIL bp spurious o=%h want none", o);
            else begin
               e = sb_q.pop_front();
               if ({o, flags} !== e)
                  $display("FAIL bp o/flags got %h/%b want %h/%b", o, flags, e[19:4], e[3:0]);
               else passes++;
            end
         end
         if (i < 6) begin
            {a, b} = tv[idx[i]][51:20];
            in_valid = 1'b1;
            if (in_ready) begin
               sb_q.push_back(tv[idx[i]][19:0]);
               i++;
            end
         end else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (saw_block !== 1'b1) $display("FAIL bp_in_ready_drop got %b want 1", saw_block);
      else passes++;
      checks++;
      if (got != 6 || sb_q.size() != 0) begin
         $display("FAIL bp_count got %0d results want 6", got);
         sb_q.delete();
      end else passes++;
   endtask

   task automatic test_reset_midstream();
      logic stale = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         {a, b} = tv[k][51:20];
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) $display("FAIL mid_pre out_valid got %b want 1", out_valid);
      else passes++;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", out_valid);
      else passes++;
      checks++;
      if (o !== 16'h0000) $display("FAIL mid_rst_o got %h want 0000", o);
      else passes++;
      checks++;
      if (flags !== 4'b0000) $display("FAIL mid_rst_flags got %b want 0000", flags);
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      checks++;
      if (stale !== 1'b0) $display("FAIL mid_stale got %b want 0", stale);
      else passes++;
      {a, b} = tv[14][51:20];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL mid_lat_c1 got %b want 0", out_valid);
      else passes++;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("FAIL mid_lat_c2 got %b want 0", out_valid);
      else passes++;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || {o, flags} !== tv[14][19:0])
         $display("FAIL mid_lat_c3 v/o/flags got %b/%h/%b want 1/%h/%b",
                  out_valid, o, flags, tv[14][19:4], tv[14][3:0]);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_specials();
      test_rounding();
      test_back_to_back();
      test_reset_midstream();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
